apb_timer: RTL

- APB4 slave programmable down-counting timer with prescaler, auto-reload/one-shot modes and a level interrupt.
- Sits on the local APB4 bus directly downstream of the AHB3-lite-to-APB4 bridge, alongside the GPIO peripheral.
- irq_o feeds one bit of the SoC IRQ vector into the Cortex-M3 core.
- Gives firmware a periodic tick and delay source.

---
 rtl/apb_timer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apb_timer.sv
// APB4 down-counting timer: prescaler, auto-reload or one-shot, level interrupt.
// Registers: CTRL(0) PRESCALE(1) LOAD(2) COUNT(3) STATUS(4); other word indices are unmapped.
module apb_timer #(
  parameter int PDATA_SIZE = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [3:0]              PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    irq_o
);

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_PRESCALE = 4'd1;
  localparam logic [3:0] A_LOAD     = 4'd2;
  localparam logic [3:0] A_COUNT    = 4'd3;
  localparam logic [3:0] A_STATUS   = 4'd4;

  logic                  r_en;
  logic                  r_oneshot;
  logic                  r_irqen;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [PDATA_SIZE-1:0] r_load;
  logic [PDATA_SIZE-1:0] r_count;
  logic                  r_if;

  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_prescale;
  logic w_wr_load;
  logic w_wr_count;
  logic w_if_clr;
  logic w_tick;
  logic w_zero;
  logic w_event;

  assign w_wr          = PSEL & PENABLE & PWRITE;
  assign w_wr_ctrl     = w_wr & (PADDR == A_CTRL);
  assign w_wr_prescale = w_wr & (PADDR == A_PRESCALE);
  assign w_wr_load     = w_wr & (PADDR == A_LOAD);
  assign w_wr_count    = w_wr & (PADDR == A_COUNT);
  assign w_if_clr      = w_wr & (PADDR == A_STATUS) & PSTRB[0] & PWDATA[0];

  assign w_tick  = r_en & (r_pcnt == r_prescale);
  assign w_zero  = (r_count == '0);
  assign w_event = w_tick & w_zero;

  // A PRESCALE written below pcnt lets pcnt run to all-ones and wrap silently.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pcnt <= '0;
    end else if (!r_en || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // A CTRL write on the same edge overrides the one-shot auto-disable.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_irqen   <= 1'b0;
    end else if (w_wr_ctrl && PSTRB[0]) begin
      r_en      <= PWDATA[0];
      r_oneshot <= PWDATA[1];
      r_irqen   <= PWDATA[2];
    end else if (w_event && r_oneshot) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prescale <= '0;
    end else if (w_wr_prescale) begin
      for (int i = 0; i < PRESCALE_W; i++) begin
        if (PSTRB[i/8]) r_prescale[i] <= PWDATA[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_load <= '0;
    end else if (w_wr_load) begin
      for (int i = 0; i < PDATA_SIZE; i++) begin
        if (PSTRB[i/8]) r_load[i] <= PWDATA[i];
      end
    end
  end

  // A bus write to COUNT discards that edge's decrement or reload.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      for (int i = 0; i < PDATA_SIZE; i++) begin
        if (PSTRB[i/8]) r_count[i] <= PWDATA[i];
      end
    end else if (w_tick) begin
      r_count <= w_zero ? r_load : r_count - 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_if <= 1'b0;
    end else if (w_event) begin
      r_if <= 1'b1;
    end else if (w_if_clr) begin
      r_if <= 1'b0;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        A_CTRL:     PRDATA[2:0] = {r_irqen, r_oneshot, r_en};
        A_PRESCALE: PRDATA[PRESCALE_W-1:0] = r_prescale;
        A_LOAD:     PRDATA = r_load;
        A_COUNT:    PRDATA = r_count;
        A_STATUS:   PRDATA[0] = r_if;
        default:    PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (PADDR > A_STATUS);
  assign irq_o   = r_if & r_irqen;

endmodule
